// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator sequencer: FSM state encodings,
// opcode constants, the phase codes shown on Display and the Leds progress
// bar patterns.
// -----------------------------------------------------------------------------
package calc_pkg;

  // FSM states; the encodings are visible to anyone probing the state register
  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_WITH_A  = 3'b001,
    ST_WITH_B  = 3'b010,
    ST_COMPUTE = 3'b011,
    ST_RESULT  = 3'b100
  } state_e;

  // Opcodes, held 8 bits wide so any legal OP_WIDTH (3..8) zero-extends onto them
  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_AND = 8'd2;
  localparam logic [7:0] OP_OR  = 8'd3;
  localparam logic [7:0] OP_XOR = 8'd4;
  localparam logic [7:0] OP_NOT = 8'd5;
  localparam logic [7:0] OP_SHL = 8'd6;
  localparam logic [7:0] OP_SHR = 8'd7;

  // Display phase codes (COMPUTE and RESULT share a code)
  localparam logic [2:0] DISP_IDLE    = 3'b100;
  localparam logic [2:0] DISP_WITH_A  = 3'b001;
  localparam logic [2:0] DISP_WITH_B  = 3'b010;
  localparam logic [2:0] DISP_COMPUTE = 3'b011;
  localparam logic [2:0] DISP_RESULT  = 3'b011;

  // Leds progress bar, one more LED lit per completed step
  localparam logic [3:0] LEDS_IDLE    = 4'b0001;
  localparam logic [3:0] LEDS_WITH_A  = 4'b0011;
  localparam logic [3:0] LEDS_WITH_B  = 4'b0111;
  localparam logic [3:0] LEDS_COMPUTE = 4'b0111;
  localparam logic [3:0] LEDS_RESULT  = 4'b1111;

  // Result flags as latched at the end of COMPUTE
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
  } flags_t;

endpackage

// File: rtl/calc_sequencer_if.sv
// -----------------------------------------------------------------------------
// calc_sequencer_if
// Front-panel bundle of the calculator: switches and push-buttons in,
// displayed value, phase code, progress LEDs, flags and Busy out.
//   Switchs   : operand in [WIDTH-1:0], opcode in the top OP_WIDTH bits
//   Enter     : push-button, asynchronous, active-high
//   Clear     : push-button, asynchronous, active-high
//   ValueOut  : displayed value
//   Display   : phase code
//   Leds      : progress bar
//   Zero, Carry_out, Overflow : result flags (only shown in RESULT)
//   Busy      : high while computing
// Modports: master = panel/driver side, slave = calculator side.
// -----------------------------------------------------------------------------
interface calc_sequencer_if #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
);

  logic [WIDTH+OP_WIDTH-1:0] Switchs;
  logic                      Enter;
  logic                      Clear;
  logic [WIDTH-1:0]          ValueOut;
  logic [2:0]                Display;
  logic [3:0]                Leds;
  logic                      Zero;
  logic                      Carry_out;
  logic                      Overflow;
  logic                      Busy;

  modport master (
    output Switchs, Enter, Clear,
    input  ValueOut, Display, Leds, Zero, Carry_out, Overflow, Busy
  );

  modport slave (
    input  Switchs, Enter, Clear,
    output ValueOut, Display, Leds, Zero, Carry_out, Overflow, Busy
  );

endinterface

// File: rtl/calc_alu.sv
// -----------------------------------------------------------------------------
// calc_alu
// Purely combinational arithmetic/logic unit for the calculator.
// Parameters: WIDTH (operand width, 4..32), OP_WIDTH (opcode width, 3..8).
// Ports:
//   a_i, b_i    : operands
//   op_i        : opcode (see calc_pkg); undefined codes give result 0
//   result_o    : result
//   carry_o     : carry for ADD, borrow for SUB, shifted-out bit for shifts
//   zero_o      : result == 0
//   overflow_o  : two's-complement overflow for ADD/SUB
// -----------------------------------------------------------------------------
module calc_alu
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
) (
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  input  logic [OP_WIDTH-1:0] op_i,
  output logic [WIDTH-1:0]    result_o,
  output logic                carry_o,
  output logic                zero_o,
  output logic                overflow_o
);

  localparam int MSB = WIDTH - 1;

  logic [7:0]     op_ext;
  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] diff_w;

  assign op_ext = 8'(op_i);

  // One extra bit on each so the top bit carries the carry/borrow
  assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
  assign diff_w = {1'b0, a_i} - {1'b0, b_i};

  // Operation select; overflow is detected from operand and result signs
  always_comb begin
    result_o   = '0;
    carry_o    = 1'b0;
    overflow_o = 1'b0;
    case (op_ext)
      OP_ADD: begin
        result_o   = sum_w[WIDTH-1:0];
        carry_o    = sum_w[WIDTH];
        overflow_o = (a_i[MSB] == b_i[MSB]) && (sum_w[MSB] != a_i[MSB]);
      end
      OP_SUB: begin
        result_o   = diff_w[WIDTH-1:0];
        carry_o    = diff_w[WIDTH];
        overflow_o = (a_i[MSB] != b_i[MSB]) && (diff_w[MSB] != a_i[MSB]);
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      OP_SHL: begin
        result_o = {a_i[WIDTH-2:0], 1'b0};
        carry_o  = a_i[MSB];
      end
      OP_SHR: begin
        result_o = {1'b0, a_i[WIDTH-1:1]};
        carry_o  = a_i[0];
      end
      default: begin
        result_o = '0;
      end
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
// Push-button calculator sequencer. The user enters A, then B, then an
// opcode with the Enter button; one COMPUTE cycle later the result and its
// flags are shown. Clear returns to IDLE from anywhere.
// Parameters: WIDTH (4..32), OP_WIDTH (3..8).
// Ports:
//   clock   : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : calc_sequencer_if.slave front-panel bundle
// Build option: define CALC_CHAIN_EN to make an Enter in RESULT load the
// previous result into A (accumulator chaining) instead of the switches.
// -----------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  calc_sequencer_if.slave   bus
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [OP_WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0]    result_q, result_d;
  flags_t              flags_q, flags_d;

  logic [1:0]          enter_sync_q, enter_sync_d;
  logic [1:0]          clear_sync_q, clear_sync_d;
  logic [1:0]          sync_vld_q, sync_vld_d;
  logic                enter_armed_q, enter_armed_d;

  logic                enter_s;
  logic                clear_s;
  logic                enter_evt;

  logic [WIDTH-1:0]    sw_operand;
  logic [OP_WIDTH-1:0] sw_opcode;

  logic [WIDTH-1:0]    alu_result;
  logic                alu_carry;
  logic                alu_zero;
  logic                alu_overflow;

  assign sw_operand = bus.Switchs[WIDTH-1:0];
  assign sw_opcode  = bus.Switchs[WIDTH+OP_WIDTH-1:WIDTH];

  assign enter_s   = enter_sync_q[1];
  assign clear_s   = clear_sync_q[1];
  assign enter_evt = enter_s && enter_armed_q;

  calc_alu #(
    .WIDTH    (WIDTH),
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .a_i        (a_q),
    .b_i        (b_q),
    .op_i       (op_q),
    .result_o   (alu_result),
    .carry_o    (alu_carry),
    .zero_o     (alu_zero),
    .overflow_o (alu_overflow)
  );

  // Button synchronisers and Enter edge detection. The event fires when the
  // synchronised Enter is high while armed, and disarms until Enter is seen
  // low again. sync_vld_q holds off arming until the synchronisers carry a
  // real sample after reset, so a button held through reset never fires.
  always_comb begin
    enter_sync_d  = {enter_sync_q[0], bus.Enter};
    clear_sync_d  = {clear_sync_q[0], bus.Clear};
    sync_vld_d    = {sync_vld_q[0], 1'b1};
    enter_armed_d = enter_armed_q;
    if (enter_evt) begin
      enter_armed_d = 1'b0;
    end else if (sync_vld_q[1] && !enter_s) begin
      enter_armed_d = 1'b1;
    end
  end

  // Next-state and datapath register updates; Clear overrides everything,
  // including a same-cycle Enter event and the COMPUTE latch
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (clear_s) begin
      state_d  = ST_IDLE;
      a_d      = '0;
      b_d      = '0;
      op_d     = '0;
      result_d = '0;
      flags_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enter_evt) begin
            a_d     = sw_operand;
            state_d = ST_WITH_A;
          end
        end
        ST_WITH_A: begin
          if (enter_evt) begin
            b_d     = sw_operand;
            state_d = ST_WITH_B;
          end
        end
        ST_WITH_B: begin
          if (enter_evt) begin
            op_d    = sw_opcode;
            state_d = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          result_d         = alu_result;
          flags_d.zero     = alu_zero;
          flags_d.carry    = alu_carry;
          flags_d.overflow = alu_overflow;
          state_d          = ST_RESULT;
        end
        ST_RESULT: begin
          if (enter_evt) begin
`ifdef CALC_CHAIN_EN
            a_d = result_q;
`else
            a_d = sw_operand;
`endif
            state_d = ST_WITH_A;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and synchroniser registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      enter_sync_q  <= '0;
      clear_sync_q  <= '0;
      sync_vld_q    <= '0;
      enter_armed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      result_q      <= result_d;
      flags_q       <= flags_d;
      enter_sync_q  <= enter_sync_d;
      clear_sync_q  <= clear_sync_d;
      sync_vld_q    <= sync_vld_d;
      enter_armed_q <= enter_armed_d;
    end
  end

  // Moore output decode; flags are only shown while the result is displayed
  always_comb begin
    bus.ValueOut  = '0;
    bus.Display   = DISP_IDLE;
    bus.Leds      = LEDS_IDLE;
    bus.Busy      = 1'b0;
    bus.Zero      = 1'b0;
    bus.Carry_out = 1'b0;
    bus.Overflow  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.ValueOut = '0;
        bus.Display  = DISP_IDLE;
        bus.Leds     = LEDS_IDLE;
      end
      ST_WITH_A: begin
        bus.ValueOut = a_q;
        bus.Display  = DISP_WITH_A;
        bus.Leds     = LEDS_WITH_A;
      end
      ST_WITH_B: begin
        bus.ValueOut = b_q;
        bus.Display  = DISP_WITH_B;
        bus.Leds     = LEDS_WITH_B;
      end
      ST_COMPUTE: begin
        bus.ValueOut = '0;
        bus.Display  = DISP_COMPUTE;
        bus.Leds     = LEDS_COMPUTE;
        bus.Busy     = 1'b1;
      end
      ST_RESULT: begin
        bus.ValueOut  = result_q;
        bus.Display   = DISP_RESULT;
        bus.Leds      = LEDS_RESULT;
        bus.Zero      = flags_q.zero;
        bus.Carry_out = flags_q.carry;
        bus.Overflow  = flags_q.overflow;
      end
      default: begin
        bus.ValueOut = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
// Drives an 8-bit and a 16-bit calculator from the same buttons. Expected
// results come from an independent reference model, are queued when the
// opcode is entered and are popped when the result appears.
// Honours CALC_CHAIN_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

  logic clock = 1'b0;
  logic reset_n;

  calc_sequencer_if #(.WIDTH(8),  .OP_WIDTH(4)) bus8();
  calc_sequencer_if #(.WIDTH(16), .OP_WIDTH(4)) bus16();

  calc_sequencer #(.WIDTH(8), .OP_WIDTH(4)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8.slave)
  );

  calc_sequencer #(.WIDTH(16), .OP_WIDTH(4)) dut16 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus16.slave)
  );

  // Both calculators share the push-buttons
  assign bus16.Enter = bus8.Enter;
  assign bus16.Clear = bus8.Clear;

  // 100 MHz-style free-running clock
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] value;
    logic        carry;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   checkCount = 0;
  int   passCount  = 0;

  // Single comparison point: counts every check, reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference model written from the opcode table with wide integer math
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input int op, input int w);
    exp_t   r;
    longint mask, ua, ub, full, sa, sb, sr, maxv, minv;
    mask = (longint'(1) << w) - 1;
    ua   = longint'(a) & mask;
    ub   = longint'(b) & mask;
    sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
    sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
    maxv = mask >> 1;
    minv = -(maxv + 1);
    r    = '0;
    full = 0;
    case (op)
      0: begin
        full    = ua + ub;
        r.carry = ((full >> w) & 1) != 0;
        full    = full & mask;
        sr      = sa + sb;
        r.ovf   = (sr > maxv) || (sr < minv);
      end
      1: begin
        full    = (ua - ub) & mask;
        r.carry = ua < ub;
        sr      = sa - sb;
        r.ovf   = (sr > maxv) || (sr < minv);
      end
      2: full = ua & ub;
      3: full = ua | ub;
      4: full = ua ^ ub;
      5: full = (~ua) & mask;
      6: begin
        full    = (ua << 1) & mask;
        r.carry = ((ua >> (w - 1)) & 1) != 0;
      end
      7: begin
        full    = ua >> 1;
        r.carry = (ua & 1) != 0;
      end
      default: full = 0;
    endcase
    r.value = 16'(full);
    r.zero  = (full == 0);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Press and hold Enter long enough for one event, then release and re-arm
  task automatic pressEnter(input logic [7:0] a8, input logic [15:0] a16);
    bus8.Switchs  = {4'h0, a8};
    bus16.Switchs = {4'h0, a16};
    bus8.Enter    = 1'b1;
    tick(4);
    bus8.Enter    = 1'b0;
    tick(3);
  endtask

  task automatic clearPulse();
    bus8.Clear = 1'b1;
    tick(4);
    checkOutput("clear.display", 32'(bus8.Display), 32'h4);
    checkOutput("clear.value",   32'(bus8.ValueOut), 32'h0);
    bus8.Clear = 1'b0;
    tick(3);
  endtask

  // Full A, B, opcode sequence on both calculators with scoreboard checking
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] op,
                               input logic [15:0] a16, input logic [15:0] b16);
    exp_t e;
    int   busyCycles;
    logic reached;
    clearPulse();
    pressEnter(a, a16);
    checkOutput($sformatf("op%0d.withA.display", op), 32'(bus8.Display), 32'h1);
    checkOutput($sformatf("op%0d.withA.value", op),   32'(bus8.ValueOut), 32'(a));
    pressEnter(b, b16);
    checkOutput($sformatf("op%0d.withB.leds", op),    32'(bus8.Leds), 32'h7);
    checkOutput($sformatf("op%0d.withB.value", op),   32'(bus8.ValueOut), 32'(b));
    bus8.Switchs  = {op, 8'h00};
    bus16.Switchs = {op, 16'h0000};
    q8.push_back(model(32'(a), 32'(b), int'(op), 8));
    q16.push_back(model(32'(a16), 32'(b16), int'(op), 16));
    bus8.Enter = 1'b1;
    busyCycles = 0;
    reached    = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      @(posedge clock);
      #1;
      if (bus8.Busy) busyCycles++;
      if (bus8.Leds == 4'b1111) reached = 1'b1;
    end
    checkOutput($sformatf("op%0d.resultReached", op), 32'(reached), 32'h1);
    checkOutput($sformatf("op%0d.busyCycles", op), 32'(busyCycles), 32'h1);
    checkOutput($sformatf("op%0d.result.display", op), 32'(bus8.Display), 32'h3);
    e = q8.pop_front();
    checkOutput($sformatf("op%0d.value8", op), 32'(bus8.ValueOut), 32'(e.value[7:0]));
    checkOutput($sformatf("op%0d.carry8", op), 32'(bus8.Carry_out), 32'(e.carry));
    checkOutput($sformatf("op%0d.zero8", op),  32'(bus8.Zero), 32'(e.zero));
    checkOutput($sformatf("op%0d.ovf8", op),   32'(bus8.Overflow), 32'(e.ovf));
    e = q16.pop_front();
    checkOutput($sformatf("op%0d.value16", op), 32'(bus16.ValueOut), 32'(e.value));
    checkOutput($sformatf("op%0d.carry16", op), 32'(bus16.Carry_out), 32'(e.carry));
    checkOutput($sformatf("op%0d.zero16", op),  32'(bus16.Zero), 32'(e.zero));
    checkOutput($sformatf("op%0d.ovf16", op),   32'(bus16.Overflow), 32'(e.ovf));
    bus8.Enter = 1'b0;
    tick(3);
  endtask

  // Safety net in case something never settles
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] chainExp;
    logic       seenBusy;
    reset_n       = 1'b0;
    bus8.Switchs  = '0;
    bus16.Switchs = '0;
    bus8.Enter    = 1'b0;
    bus8.Clear    = 1'b0;
    tick(3);
    checkOutput("reset.display", 32'(bus8.Display), 32'h4);
    checkOutput("reset.leds",    32'(bus8.Leds), 32'h1);
    checkOutput("reset.value",   32'(bus8.ValueOut), 32'h0);
    checkOutput("reset.busy",    32'(bus8.Busy), 32'h0);
    checkOutput("reset.flags",   32'({bus8.Zero, bus8.Carry_out, bus8.Overflow}), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    tick(3);

    // Signed overflow in 8 bits, unsigned carry-out and zero in 16 bits
    applyStimulus(8'h7F, 8'h01, 4'd0, 16'hFFFF, 16'h0001);

    // Enter in RESULT reloads A from switches, or from the result when chaining
`ifdef CALC_CHAIN_EN
    chainExp = 8'h80;
`else
    chainExp = 8'h11;
`endif
    pressEnter(8'h11, 16'h0011);
    checkOutput("chain.display", 32'(bus8.Display), 32'h1);
    checkOutput("chain.value",   32'(bus8.ValueOut), 32'(chainExp));

    applyStimulus(8'h05, 8'h05, 4'd1, 16'h1234, 16'h1234);
    applyStimulus(8'h00, 8'h01, 4'd1, 16'h0000, 16'h0001);
    applyStimulus(8'h80, 8'h01, 4'd1, 16'h8000, 16'h0001);
    applyStimulus(8'hFF, 8'h01, 4'd0, 16'h7FFF, 16'h0001);
    applyStimulus(8'hA5, 8'h3C, 4'd2, 16'hA5F0, 16'h3C0F);
    applyStimulus(8'hA5, 8'h3C, 4'd3, 16'hA5F0, 16'h3C0F);
    applyStimulus(8'hA5, 8'h3C, 4'd4, 16'hA5F0, 16'h3C0F);
    applyStimulus(8'hA5, 8'h00, 4'd5, 16'hA5F0, 16'h0000);
    applyStimulus(8'h81, 8'h00, 4'd6, 16'h8001, 16'h0000);
    applyStimulus(8'h03, 8'h00, 4'd7, 16'h0003, 16'h0000);
    applyStimulus(8'h12, 8'h34, 4'd9, 16'h1234, 16'h5678);

    // Long hold gives exactly one event; switch changes mid-hold are ignored
    clearPulse();
    bus8.Switchs = {4'h0, 8'h3C};
    bus8.Enter   = 1'b1;
    tick(10);
    bus8.Switchs = {4'h0, 8'h55};
    tick(40);
    checkOutput("hold.display", 32'(bus8.Display), 32'h1);
    checkOutput("hold.value",   32'(bus8.ValueOut), 32'h3C);
    bus8.Enter = 1'b0;
    tick(3);
    checkOutput("hold.release.display", 32'(bus8.Display), 32'h1);

    // Clear and Enter together in WITH_B: Clear wins, held Enter stays spent
    clearPulse();
    pressEnter(8'h11, 16'h0011);
    pressEnter(8'h22, 16'h0022);
    checkOutput("clrEnt.pre.display", 32'(bus8.Display), 32'h2);
    bus8.Switchs = {4'd1, 8'h00};
    bus8.Enter   = 1'b1;
    bus8.Clear   = 1'b1;
    tick(5);
    checkOutput("clrEnt.display", 32'(bus8.Display), 32'h4);
    checkOutput("clrEnt.value",   32'(bus8.ValueOut), 32'h0);
    bus8.Clear = 1'b0;
    tick(5);
    checkOutput("clrEnt.after.display", 32'(bus8.Display), 32'h4);
    bus8.Enter = 1'b0;
    tick(3);

    // Reset in the middle of COMPUTE, with Enter held through reset release
    pressEnter(8'h7F, 16'h7FFF);
    pressEnter(8'h01, 16'h0001);
    bus8.Switchs = {4'd0, 8'h00};
    bus8.Enter   = 1'b1;
    seenBusy     = 1'b0;
    for (int i = 0; i < 10 && !seenBusy; i++) begin
      @(posedge clock);
      #1;
      if (bus8.Busy) seenBusy = 1'b1;
    end
    checkOutput("rstCompute.busySeen", 32'(seenBusy), 32'h1);
    reset_n = 1'b0;
    #1;
    checkOutput("rstCompute.display", 32'(bus8.Display), 32'h4);
    checkOutput("rstCompute.leds",    32'(bus8.Leds), 32'h1);
    checkOutput("rstCompute.value",   32'(bus8.ValueOut), 32'h0);
    checkOutput("rstCompute.busy",    32'(bus8.Busy), 32'h0);
    checkOutput("rstCompute.flags",   32'({bus8.Zero, bus8.Carry_out, bus8.Overflow}), 32'h0);
    tick(2);
    @(negedge clock);
    reset_n = 1'b1;
    tick(10);
    checkOutput("heldThroughReset.display", 32'(bus8.Display), 32'h4);
    bus8.Enter = 1'b0;
    tick(4);
    pressEnter(8'h22, 16'h0022);
    checkOutput("rearm.display", 32'(bus8.Display), 32'h1);
    checkOutput("rearm.value",   32'(bus8.ValueOut), 32'h22);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand/result width (legal 4..32).
REQ-002 The module SHALL have parameter OP_WIDTH, default 4, opcode width (legal 3..8).
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock; all flops update on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port Switchs, input, WIDTH+OP_WIDTH bits, operand in [WIDTH-1:0] and opcode in the top OP_WIDTH bits.
REQ-006 The module SHALL have ports Enter and Clear, inputs, 1 bit each, asynchronous push-buttons, active-high.
REQ-007 The module SHALL have port ValueOut, output, WIDTH bits, the displayed value.
REQ-008 The module SHALL have port Display, output, 3 bits, the phase code.
REQ-009 The module SHALL have port Leds, output, 4 bits, the progress bar.
REQ-010 The module SHALL have ports Zero, Carry_out and Overflow, outputs, 1 bit each, the result flags.
REQ-011 The module SHALL have port Busy, output, 1 bit, high while computing.

Function
REQ-012 Enter and Clear SHALL each pass through a 2-flop synchroniser; an Enter event is a rising edge at the synchroniser output, so a press at edge n acts at edge n+3.
REQ-013 Holding Enter for any number of cycles SHALL produce exactly one event; re-arming requires Enter low for at least 1 synchronised cycle.
REQ-014 FSM states and encodings SHALL be IDLE 000, WITH_A 001, WITH_B 010, COMPUTE 011 and RESULT 100.
REQ-015 In IDLE, an Enter event SHALL set A=Switchs[WIDTH-1:0] and go to WITH_A.
REQ-016 In WITH_A, an Enter event SHALL set B=Switchs[WIDTH-1:0] and go to WITH_B.
REQ-017 In WITH_B, an Enter event SHALL set Op=opcode field and go to COMPUTE.
REQ-018 COMPUTE SHALL last exactly 1 cycle, latch result and flags into registers, and go to RESULT unconditionally.
REQ-019 In RESULT, an Enter event SHALL set A=Switchs[WIDTH-1:0] and go to WITH_A.
REQ-020 When synchronised Clear is high, in any state including COMPUTE, the block SHALL go to IDLE and zero A, B, Op, the result register and the flags.
REQ-021 Clear SHALL have priority over an Enter event in the same cycle.
REQ-022 Ops SHALL be 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A<<1, 7 A>>1 (logical); any other code SHALL give result 0.
REQ-023 Carry_out SHALL be the carry out of bit WIDTH-1 for ADD, 1 on borrow for SUB, the shifted-out bit for shifts, and 0 otherwise.
REQ-024 Overflow SHALL be two's-complement overflow for ADD/SUB and 0 otherwise; Zero SHALL be (result==0).
REQ-025 Outputs SHALL decode from registered state and data (Moore): IDLE ValueOut 0/Display 100/Leds 0001; WITH_A A/001/0011; WITH_B B/010/0111; COMPUTE 0/011/0111; RESULT result/011/1111.
REQ-026 Busy SHALL be 1 only in COMPUTE; flag outputs SHALL be the flag registers gated to 0 outside RESULT.

Reset
REQ-027 When reset_n is low, the block SHALL immediately set state IDLE, clear A, B, Op, the result, the flags and the synchronisers, and drive outputs to their IDLE values, regardless of the state at the time.
REQ-028 After reset_n deasserts, an Enter already held high SHALL NOT generate an event until it is released and pressed again.

Configuration
REQ-029 When CALC_CHAIN_EN is defined, an Enter event in RESULT SHALL set A to the result register instead of the switches (accumulator chaining); when it is not defined, REQ-019 SHALL apply.

Structure
REQ-030 Package calc_pkg SHALL hold the state encodings, opcode constants, Display codes and Leds codes.
REQ-031 The arithmetic SHALL be a combinational sub-module calc_alu #(WIDTH,OP_WIDTH) producing the result, Carry_out, Zero and Overflow, with no state.

Verification
REQ-032 With WIDTH=8, entering A=7F, B=01, op ADD SHALL give ValueOut=80, Overflow=1, Carry_out=0, Zero=0, and Busy high for exactly 1 cycle.
REQ-033 With WIDTH=8, entering A=05, B=05, op SUB SHALL give ValueOut=00, Zero=1, Carry_out=0; A=00, B=01, op SUB SHALL give FF with Carry_out=1.
REQ-034 Holding Enter high for 50 cycles in IDLE SHALL advance the state only to WITH_A, with A captured once.
REQ-035 Clear and Enter rising in the same cycle during WITH_B SHALL leave the block in IDLE with Op=0 and ValueOut=0.
REQ-036 Asserting reset_n low mid-COMPUTE SHALL immediately give IDLE outputs and flags 0; with CALC_CHAIN_EN defined, an Enter event in RESULT after 7F+01 SHALL give A=80 in WITH_A.
REQ-037 With WIDTH=16, entering A=FFFF, B=0001, op ADD SHALL give ValueOut=0000, Carry_out=1, Zero=1.
